isqrt16: RTL
============

# isqrt16

Sequential unsigned integer square-root unit placed directly downstream of the 8x8 sequential multiplier: it consumes the multiplier's 16-bit product and returns floor(sqrt(x)) as an 8-bit result. Uses the same start/busy handshake as the multiplier, so a controller can chain the two: the multiplier's busy falls, then the controller pulses this block's start. One result bit is resolved per clock, using the shift-subtract (digit-by-digit) method with no multiplier or divider.

## Interface
- Parameters: none; widths are fixed at 16-bit in, 8-bit out.
- clk_i  input  1  clock; all state changes on rising edge.
- rst_i  input  1  reset, asynchronous, active-low; 0 forces reset state immediately.
- x_bi  input  16  unsigned radicand; sampled only on the accepting edge.
- start_i  input  1  request; sampled every rising edge, acted on only in IDLE.
- busy_o  output  1  registered; 1 while a computation is in progress.
- y_bo  output  8  registered result floor(sqrt(x)); holds the last completed result.

## Operation
- FSM with two states: IDLE and WORK.
- Internal registers:
  - x_r: 16-bit remainder
  - part_r: 16-bit partial root
  - m_r: 16-bit bit-mask
  - result register driving y_bo
- IDLE, start_i=1 at an edge:
  - x_r <= x_bi, part_r <= 0, m_r <= 16'h4000
  - state <= WORK, busy_o <= 1
- IDLE, start_i=0: all registers hold.
- WORK, one iteration per edge:
  - b = part_r | m_r, computed as a 16-bit unsigned value
  - if x_r >= b: x_r <= x_r - b, part_r <= (part_r >> 1) | m_r
  - else: x_r holds, part_r <= part_r >> 1
  - m_r <= m_r >> 2
- Completion occurs on the WORK edge where m_r == 16'h0001, which is the 8th iteration:
  - the same edge writes y_bo <= low 8 bits of the final part_r value
  - state <= IDLE, busy_o <= 0
- Arithmetic rules:
  - every comparison and subtraction is unsigned, 16-bit
  - the subtraction never underflows, because it is guarded by the comparison
  - the final part_r is always <= 255
- start_i while in WORK is ignored: no restart, no queueing.
- x_bi changes while in WORK have no effect.
- y_bo is never driven with intermediate values; it changes only on the completion edge.

## Timing
- Reset (rst_i=0, asynchronous): state=IDLE, busy_o=0, y_bo=8'h00, all internal registers 0.
- Reset mid-operation aborts the computation; no result is written. The block accepts start on the first rising edge after rst_i returns to 1.
- Latency:
  - edge E0 accepts start; busy_o rises after E0
  - edges E1..E8 perform the 8 iterations
  - busy_o falls and y_bo becomes valid after E8
  - busy_o is high for exactly 8 clock cycles
- Start asserted on the edge where busy_o falls (E8) is ignored, because the state is still WORK at that edge.
- Earliest next accept is E9, so back-to-back throughput is 1 result per 9 cycles when start_i is held high.
- start_i held high continuously: after a completion, a new computation starts on the next edge using the current x_bi.
- A 1-cycle start pulse is sufficient; start_i has no minimum width beyond one sampled edge.

## Test plan
- Reset, then start with x=0 → busy_o high for 8 cycles, then y_bo=0.
- x=65535 → y_bo=255; x=65025 (the multiplier's 255*255 result) → y_bo=255.
- x=1872 (16*117) → y_bo=43; x=15 → 3; x=16 → 4. Busy falls exactly 8 cycles after the accepting edge in each case.
- Pulse start with x=100; 3 cycles later pulse start with x=9 and change x_bi → y_bo=10, no restart, busy width still 8.
- Start with x=40000, deassert rst_i at iteration 4 → busy_o=0 and y_bo=0 immediately. After release, start with x=49 → y_bo=7.
- Sweep all 65536 inputs back-to-back with start_i held high → every result equals floor(sqrt(x)), and results are spaced 9 cycles apart.

Source files
------------

// File: rtl/isqrt16.sv
// ============================================================================
// Module   : isqrt16
// Purpose  : Sequential 16-bit unsigned integer square root, one root bit per
//            clock (shift-subtract), start/busy handshake, 8-bit result.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module isqrt16 (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [15:0] x_bi,
    input  logic        start_i,
    output logic        busy_o,
    output logic [7:0]  y_bo
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        WORK = 1'b1
    } state_t;

    localparam logic [15:0] C_MASK_INIT = 16'h4000;
    localparam logic [15:0] C_MASK_LAST = 16'h0001;

    state_t      r_state, w_state_n;
    logic [15:0] r_x,     w_x_n;
    logic [15:0] r_part,  w_part_n;
    logic [15:0] r_mask,  w_mask_n;
    logic [7:0]  r_y,     w_y_n;
    logic        r_busy,  w_busy_n;

    logic [15:0] w_trial;
    logic        w_fits;

    assign w_trial = r_part | r_mask;
    assign w_fits  = (r_x >= w_trial);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state <= IDLE;
            r_x     <= 16'h0000;
            r_part  <= 16'h0000;
            r_mask  <= 16'h0000;
            r_y     <= 8'h00;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_n;
            r_x     <= w_x_n;
            r_part  <= w_part_n;
            r_mask  <= w_mask_n;
            r_y     <= w_y_n;
            r_busy  <= w_busy_n;
        end
    end

    always_comb begin
        w_state_n = r_state;
        w_x_n     = r_x;
        w_part_n  = r_part;
        w_mask_n  = r_mask;
        w_y_n     = r_y;
        w_busy_n  = r_busy;

        case (r_state)
            IDLE: begin
                if (start_i) begin
                    w_x_n     = x_bi;
                    w_part_n  = 16'h0000;
                    w_mask_n  = C_MASK_INIT;
                    w_state_n = WORK;
                    w_busy_n  = 1'b1;
                end
            end
            WORK: begin
                // Subtraction is only taken when the trial value fits, so it cannot wrap.
                if (w_fits) begin
                    w_x_n    = r_x - w_trial;
                    w_part_n = (r_part >> 1) | r_mask;
                end else begin
                    w_part_n = r_part >> 1;
                end
                w_mask_n = r_mask >> 2;
                if (r_mask == C_MASK_LAST) begin
                    w_y_n     = w_part_n[7:0];
                    w_state_n = IDLE;
                    w_busy_n  = 1'b0;
                end
            end
            default: begin
                w_state_n = IDLE;
                w_busy_n  = 1'b0;
            end
        endcase
    end

    assign busy_o = r_busy;
    assign y_bo   = r_y;

endmodule

`default_nettype wire
